// File: rtl/sbox_ram_swap.sv
// sbox_ram_swap: a DEPTH-entry substitution table that fills itself with the
// identity map, then supports in-place two-entry swaps and single-entry writes.
// It has NUM_RD independent registered read lanes.
module sbox_ram_swap #(
  parameter int ADDR_W = 8,
  parameter int NUM_RD = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     init_start,
  output logic                     init_busy,
  input  logic                     swap_valid,
  output logic                     swap_ready,
  input  logic [ADDR_W-1:0]        swap_addr_a,
  input  logic [ADDR_W-1:0]        swap_addr_b,
  output logic                     swap_done,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [ADDR_W-1:0]        wr_data,
  output logic                     wr_drop,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*ADDR_W-1:0] rd_data
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  typedef enum logic [1:0] {
    INIT,
    IDLE,
    SWAP
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] cnt_q, cnt_d;

  // Swap operands captured at acceptance: both addresses and both old values.
  logic [ADDR_W-1:0] swap_a_q, swap_a_d;
  logic [ADDR_W-1:0] swap_b_q, swap_b_d;
  logic [ADDR_W-1:0] swap_da_q, swap_da_d;
  logic [ADDR_W-1:0] swap_db_q, swap_db_d;

  logic swap_done_q, swap_done_d;
  logic wr_drop_q, wr_drop_d;

  logic [NUM_RD*ADDR_W-1:0] rd_data_q, rd_data_d;

  // Table storage; no reset, identity content comes from the INIT fill.
  logic [ADDR_W-1:0] mem_q [DEPTH];

  // Two write ports: port A serves fill, single writes and the first swap
  // half; port B is only used for the second swap half.
  logic              we_a, we_b;
  logic [ADDR_W-1:0] waddr_a, waddr_b;
  logic [ADDR_W-1:0] wdata_a, wdata_b;

  logic swap_accept;
  logic wr_apply;

  // Handshake and write qualification; a pending init_start blocks everything.
  always_comb begin
    swap_ready  = (state_q == IDLE) && !init_start;
    swap_accept = swap_ready && swap_valid;
    wr_apply    = (state_q == IDLE) && wr_en && !swap_accept && !init_start;
  end

  // Next-state logic for the INIT / IDLE / SWAP sequencer and its registers.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    swap_a_d    = swap_a_q;
    swap_b_d    = swap_b_q;
    swap_da_d   = swap_da_q;
    swap_db_d   = swap_db_q;
    swap_done_d = 1'b0;
    wr_drop_d   = wr_en && !wr_apply;

    unique case (state_q)
      INIT: begin
        cnt_d = cnt_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        if (cnt_q == LAST_ADDR) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        if (init_start) begin
          state_d = INIT;
          cnt_d   = '0;
        end else if (swap_accept) begin
          state_d   = SWAP;
          swap_a_d  = swap_addr_a;
          swap_b_d  = swap_addr_b;
          swap_da_d = mem_q[swap_addr_a];
          swap_db_d = mem_q[swap_addr_b];
        end
      end
      SWAP: begin
        state_d     = IDLE;
        swap_done_d = 1'b1;
      end
      default: begin
        state_d = INIT;
        cnt_d   = '0;
      end
    endcase
  end

  // Memory write-port selection per state.
  always_comb begin
    we_a    = 1'b0;
    waddr_a = '0;
    wdata_a = '0;
    we_b    = 1'b0;
    waddr_b = '0;
    wdata_b = '0;

    unique case (state_q)
      INIT: begin
        we_a    = 1'b1;
        waddr_a = cnt_q;
        wdata_a = cnt_q;
      end
      IDLE: begin
        we_a    = wr_apply;
        waddr_a = wr_addr;
        wdata_a = wr_data;
      end
      SWAP: begin
        we_a    = 1'b1;
        waddr_a = swap_a_q;
        wdata_a = swap_db_q;
        we_b    = 1'b1;
        waddr_b = swap_b_q;
        wdata_b = swap_da_q;
      end
      default: begin
        we_a = 1'b0;
        we_b = 1'b0;
      end
    endcase
  end

  // Per-lane read data; the fill phase returns zeros instead of table content.
  always_comb begin
    rd_data_d = '0;
    if (state_q != INIT) begin
      for (int i = 0; i < NUM_RD; i++) begin
        rd_data_d[i*ADDR_W +: ADDR_W] = mem_q[rd_addr[i*ADDR_W +: ADDR_W]];
      end
    end
  end

  // Control and output registers; reset restarts the identity fill.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= INIT;
      cnt_q       <= '0;
      swap_a_q    <= '0;
      swap_b_q    <= '0;
      swap_da_q   <= '0;
      swap_db_q   <= '0;
      swap_done_q <= 1'b0;
      wr_drop_q   <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      swap_a_q    <= swap_a_d;
      swap_b_q    <= swap_b_d;
      swap_da_q   <= swap_da_d;
      swap_db_q   <= swap_db_d;
      swap_done_q <= swap_done_d;
      wr_drop_q   <= wr_drop_d;
      rd_data_q   <= rd_data_d;
    end
  end

  // Table writes are suppressed while reset is asserted so an interrupted swap
  // leaves memory untouched; port B is written last, which is harmless
  // because a self-swap writes the same value on both ports.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (we_a) begin
        mem_q[waddr_a] <= wdata_a;
      end
      if (we_b) begin
        mem_q[waddr_b] <= wdata_b;
      end
    end
  end

  assign init_busy = (state_q == INIT);
  assign swap_done = swap_done_q;
  assign wr_drop   = wr_drop_q;
  assign rd_data   = rd_data_q;

endmodule

// File: tb/tb_sbox_ram_swap.sv
// Directed self-checking bench for sbox_ram_swap with ADDR_W=8, NUM_RD=4.
module tb_sbox_ram_swap;

  logic        clk;
  logic        rst;
  logic        init_start;
  logic        init_busy;
  logic        swap_valid;
  logic        swap_ready;
  logic [7:0]  swap_addr_a;
  logic [7:0]  swap_addr_b;
  logic        swap_done;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        wr_drop;
  logic [31:0] rd_addr;
  logic [31:0] rd_data;

  int checks;
  int failures;
  int busyCycles;
  logic sawDone;

  sbox_ram_swap #(.ADDR_W(8), .NUM_RD(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .init_start (init_start),
    .init_busy  (init_busy),
    .swap_valid (swap_valid),
    .swap_ready (swap_ready),
    .swap_addr_a(swap_addr_a),
    .swap_addr_b(swap_addr_b),
    .swap_done  (swap_done),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_drop    (wr_drop),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] pack4(input logic [7:0] l0, input logic [7:0] l1,
                                        input logic [7:0] l2, input logic [7:0] l3);
    return {l3, l2, l1, l0};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic init, input logic valid, input logic [7:0] a,
                               input logic [7:0] b, input logic we, input logic [7:0] waddr,
                               input logic [7:0] wdata);
    init_start  = init;
    swap_valid  = valid;
    swap_addr_a = a;
    swap_addr_b = b;
    wr_en       = we;
    wr_addr     = waddr;
    wr_data     = wdata;
  endtask

  // Advance one clock; outputs are then sampled 1 ns after the edge.
  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Counts cycles with init_busy high (bounded) and notes any swap_done pulse.
  task automatic countBusy(output int n, output logic done_seen);
    n = 0;
    done_seen = 1'b0;
    while (init_busy === 1'b1 && n < 400) begin
      if (swap_done !== 1'b0) done_seen = 1'b1;
      n++;
      stepCycle();
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    rd_addr  = '0;
    applyStimulus(1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 8'd0, 8'd0);

    // Reset state
    repeat (3) stepCycle();
    checkOutput("rst_busy", 32'(init_busy), 32'd1);
    checkOutput("rst_rd", rd_data, 32'd0);
    checkOutput("rst_done", 32'(swap_done), 32'd0);
    checkOutput("rst_drop", 32'(wr_drop), 32'd0);
    checkOutput("rst_ready", 32'(swap_ready), 32'd0);

    // Initial identity fill
    rst = 1'b0;
    countBusy(busyCycles, sawDone);
    checkOutput("fill_len", 32'(busyCycles), 32'd256);
    rd_addr = pack4(8'd0, 8'd1, 8'd128, 8'd255);
    stepCycle();
    checkOutput("ident_rd", rd_data, pack4(8'd0, 8'd1, 8'd128, 8'd255));

    // Swap 3 <-> 200 with read-old-data on the swap edge
    applyStimulus(1'b0, 1'b1, 8'd3, 8'd200, 1'b0, 8'd0, 8'd0);
    rd_addr = pack4(8'd3, 8'd200, 8'd3, 8'd200);
    #1;
    checkOutput("sw_ready", 32'(swap_ready), 32'd1);
    stepCycle();
    swap_valid = 1'b0;
    checkOutput("sw_done_e0", 32'(swap_done), 32'd0);
    stepCycle();
    checkOutput("sw_done_e1", 32'(swap_done), 32'd1);
    checkOutput("sw_rd_old", rd_data, pack4(8'd3, 8'd200, 8'd3, 8'd200));
    stepCycle();
    checkOutput("sw_done_e2", 32'(swap_done), 32'd0);
    checkOutput("sw_rd_new", rd_data, pack4(8'd200, 8'd3, 8'd200, 8'd3));

    // Self-swap 7 <-> 7
    applyStimulus(1'b0, 1'b1, 8'd7, 8'd7, 1'b0, 8'd0, 8'd0);
    rd_addr = pack4(8'd7, 8'd7, 8'd7, 8'd7);
    stepCycle();
    swap_valid = 1'b0;
    stepCycle();
    checkOutput("self_done", 32'(swap_done), 32'd1);
    stepCycle();
    checkOutput("self_rd", rd_data, pack4(8'd7, 8'd7, 8'd7, 8'd7));

    // Back-to-back swaps 0 <-> 1 with swap_valid held high
    applyStimulus(1'b0, 1'b1, 8'd0, 8'd1, 1'b0, 8'd0, 8'd0);
    rd_addr = pack4(8'd0, 8'd1, 8'd0, 8'd1);
    for (int k = 0; k < 6; k++) begin
      stepCycle();
      checkOutput("b2b_done", 32'(swap_done), (k % 2 == 1) ? 32'd1 : 32'd0);
      checkOutput("b2b_ready", 32'(swap_ready), (k % 2 == 1) ? 32'd1 : 32'd0);
      if (k >= 2 && k % 2 == 0) begin
        checkOutput("b2b_rd", rd_data,
                    ((k / 2) % 2 == 1) ? pack4(8'd1, 8'd0, 8'd1, 8'd0)
                                       : pack4(8'd0, 8'd1, 8'd0, 8'd1));
      end
    end
    swap_valid = 1'b0;

    // Write colliding with an accepted swap is dropped
    applyStimulus(1'b0, 1'b1, 8'd10, 8'd11, 1'b1, 8'd50, 8'h55);
    rd_addr = pack4(8'd50, 8'd10, 8'd11, 8'd50);
    stepCycle();
    applyStimulus(1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 8'd0, 8'd0);
    checkOutput("col_drop", 32'(wr_drop), 32'd1);
    stepCycle();
    checkOutput("col_drop_off", 32'(wr_drop), 32'd0);
    checkOutput("col_done", 32'(swap_done), 32'd1);
    stepCycle();
    checkOutput("col_rd", rd_data, pack4(8'd50, 8'd11, 8'd10, 8'd50));

    // Plain write in IDLE: old data on the write edge, new data after
    applyStimulus(1'b0, 1'b0, 8'd0, 8'd0, 1'b1, 8'd5, 8'hAA);
    rd_addr = pack4(8'd5, 8'd5, 8'd5, 8'd5);
    stepCycle();
    wr_en = 1'b0;
    checkOutput("wr_drop_none", 32'(wr_drop), 32'd0);
    checkOutput("wr_rd_old", rd_data, pack4(8'd5, 8'd5, 8'd5, 8'd5));
    stepCycle();
    checkOutput("wr_rd_new", rd_data, pack4(8'hAA, 8'hAA, 8'hAA, 8'hAA));

    // Write during the SWAP cycle is dropped
    applyStimulus(1'b0, 1'b1, 8'd9, 8'd9, 1'b0, 8'd0, 8'd0);
    rd_addr = pack4(8'd6, 8'd6, 8'd6, 8'd6);
    stepCycle();
    applyStimulus(1'b0, 1'b0, 8'd0, 8'd0, 1'b1, 8'd6, 8'h66);
    stepCycle();
    wr_en = 1'b0;
    checkOutput("swp_wr_drop", 32'(wr_drop), 32'd1);
    stepCycle();
    checkOutput("swp_wr_rd", rd_data, pack4(8'd6, 8'd6, 8'd6, 8'd6));

    // Reset during SWAP aborts it; a mid-fill reset restarts the fill
    applyStimulus(1'b0, 1'b1, 8'd10, 8'd20, 1'b0, 8'd0, 8'd0);
    stepCycle();
    swap_valid = 1'b0;
    rst = 1'b1;
    stepCycle();
    checkOutput("abort_done", 32'(swap_done), 32'd0);
    checkOutput("abort_busy", 32'(init_busy), 32'd1);
    rst = 1'b0;
    repeat (100) stepCycle();
    rst = 1'b1;
    stepCycle();
    rst = 1'b0;
    countBusy(busyCycles, sawDone);
    checkOutput("refill_len", 32'(busyCycles), 32'd256);
    checkOutput("refill_nodone", 32'(sawDone), 32'd0);
    rd_addr = pack4(8'd10, 8'd20, 8'd11, 8'd5);
    stepCycle();
    checkOutput("refill_rd", rd_data, pack4(8'd10, 8'd20, 8'd11, 8'd5));

    // init_start beats a same-cycle swap request and write
    applyStimulus(1'b1, 1'b1, 8'd1, 8'd2, 1'b1, 8'd5, 8'h77);
    #1;
    checkOutput("is_ready", 32'(swap_ready), 32'd0);
    stepCycle();
    init_start = 1'b0;
    wr_en      = 1'b0;
    checkOutput("is_drop", 32'(wr_drop), 32'd1);
    countBusy(busyCycles, sawDone);
    checkOutput("is_fill_len", 32'(busyCycles), 32'd256);
    checkOutput("is_nodone", 32'(sawDone), 32'd0);
    checkOutput("is_ready_after", 32'(swap_ready), 32'd1);
    rd_addr = pack4(8'd1, 8'd2, 8'd5, 8'd0);
    stepCycle();
    swap_valid = 1'b0;
    stepCycle();
    checkOutput("is_done", 32'(swap_done), 32'd1);
    stepCycle();
    checkOutput("is_rd", rd_data, pack4(8'd2, 8'd1, 8'd5, 8'd0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
